// File: rtl/tone_period_detector_if.sv
// Signal bundle between a tone source/consumer and the tone period detector.
// The master drives the tone line and observes measurements; the slave is the detector.
interface tone_period_detector_if;
    logic        tone_in;
    logic        period_valid;
    logic [14:0] half_period;
    logic        match;
    logic        locked;
    logic        timeout;

    modport master (
        output tone_in,
        input  period_valid,
        input  half_period,
        input  match,
        input  locked,
        input  timeout
    );

    modport slave (
        input  tone_in,
        output period_valid,
        output half_period,
        output match,
        output locked,
        output timeout
    );
endinterface

// File: rtl/tone_period_detector.sv
// Measures every half-period of a square-wave tone and reports match/lock against a target.
//   state   | meaning
//   IDLE    | no reference edge yet (after reset or timeout); next edge only arms
//   MEASURE | measuring; fewer than LOCK_COUNT consecutive matches
//   LOCKED  | LOCK_COUNT consecutive matches seen, no mismatch or timeout since
module tone_period_detector #(
    parameter int TARGET_HALF = 11363,
    parameter int TOL         = 256,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tone_period_detector_if.slave bus
);

    localparam int              MCW     = $clog2(LOCK_COUNT + 1);
    localparam logic [14:0]     LO      = 15'(TARGET_HALF - TOL);
    localparam logic [14:0]     HI      = 15'(TARGET_HALF + TOL);
    localparam logic [MCW-1:0]  MC_FULL = MCW'(LOCK_COUNT);
    localparam logic [14:0]     CNT_MAX = 15'h7fff;
    localparam logic [14:0]     CNT_TO  = 15'h7ffe;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic           s1, s2, s3;
    logic [14:0]    cnt;
    logic [MCW-1:0] match_cnt;
    logic [1:0]     state;

    logic           tone_edge;
    logic [14:0]    n_meas;
    logic           in_tol;
    logic [MCW-1:0] mc_next;

    assign tone_edge = s2 ^ s3;
    assign n_meas    = cnt + 15'd1;
    assign in_tol    = (n_meas >= LO) && (n_meas <= HI);
    assign mc_next   = (match_cnt == MC_FULL) ? match_cnt : match_cnt + MCW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1               <= 1'b0;
            s2               <= 1'b0;
            s3               <= 1'b0;
            cnt              <= '0;
            match_cnt        <= '0;
            state            <= IDLE;
            bus.period_valid <= 1'b0;
            bus.half_period  <= '0;
            bus.match        <= 1'b0;
            bus.locked       <= 1'b0;
            bus.timeout      <= 1'b0;
        end else begin
            s1 <= bus.tone_in;
            s2 <= s1;
            s3 <= s2;

            bus.period_valid <= 1'b0;
            bus.timeout      <= 1'b0;

            if (tone_edge)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 15'd1;

            // An edge on the saturation cycle is a valid measurement, so it beats the timeout.
            if (tone_edge) begin
                if (state == IDLE) begin
                    state <= MEASURE;
                end else begin
                    bus.period_valid <= 1'b1;
                    bus.half_period  <= n_meas;
                    bus.match        <= in_tol;
                    if (in_tol) begin
                        match_cnt <= mc_next;
                        if (mc_next == MC_FULL) begin
                            bus.locked <= 1'b1;
                            state      <= LOCKED;
                        end
                    end else begin
                        match_cnt  <= '0;
                        bus.locked <= 1'b0;
                        state      <= MEASURE;
                    end
                end
            end else if (state != IDLE && cnt == CNT_TO) begin
                bus.timeout <= 1'b1;
                state       <= IDLE;
                bus.locked  <= 1'b0;
                bus.match   <= 1'b0;
                match_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tone_period_detector.sv
// Bench for tone_period_detector: a bench-side model predicts each measurement into a queue
// that a negedge monitor consumes; a scaled target keeps lock sequences short.
module tb_tone_period_detector;

    localparam int T  = 300;
    localparam int TL = 20;
    localparam int LC = 4;

    typedef struct packed {
        logic [14:0] half;
        logic        match;
        logic        locked;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tone_period_detector_if bus();

    tone_period_detector #(
        .TARGET_HALF (T),
        .TOL         (TL),
        .LOCK_COUNT  (LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    res_t        exp_q[$];
    res_t        mon_e, mon_g;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          tog_cyc = 0;
    int          pv_count = 0;
    int          to_count = 0;
    int          last_pv_cyc = 0;
    int          to_cyc = 0;
    logic        to_locked, to_match;
    logic [14:0] to_half;
    bit          m_armed;
    int          m_cnt;
    bit          m_locked;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.period_valid === 1'b1) begin
            pv_count++;
            last_pv_cyc = cyc;
            n_cmp++;
            mon_g = {bus.half_period, bus.match, bus.locked};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got half=%0d match=%0b locked=%0b, required no pulse",
                         mon_g.half, mon_g.match, mon_g.locked);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e) begin
                    n_err++;
                    $display("FAIL pulse_result: got half=%0d match=%0b locked=%0b, required half=%0d match=%0b locked=%0b",
                             mon_g.half, mon_g.match, mon_g.locked, mon_e.half, mon_e.match, mon_e.locked);
                end
            end
        end
        if (bus.timeout === 1'b1) begin
            to_count++;
            to_cyc    = cyc;
            to_locked = bus.locked;
            to_match  = bus.match;
            to_half   = bus.half_period;
        end
    end

    function automatic void model_edge(input int n);
        bit m;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            m = (n >= T - TL) && (n <= T + TL);
            if (m) begin
                if (m_cnt < LC) m_cnt++;
                m_locked = (m_cnt == LC);
            end else begin
                m_cnt    = 0;
                m_locked = 1'b0;
            end
            exp_q.push_back({15'(n), m, m_locked});
        end
    endfunction

    task automatic tone_half(input int n);
        do @(negedge clk); while (cyc - tog_cyc < n);
        bus.tone_in = ~bus.tone_in;
        tog_cyc = cyc;
        model_edge(n);
    endtask

    task automatic do_reset(input logic lvl);
        @(negedge clk);
        rst = 1'b1;
        bus.tone_in = lvl;
        repeat (3) @(negedge clk);
        exp_q.delete();
        m_armed  = lvl;
        m_cnt    = 0;
        m_locked = 1'b0;
        pv_count = 0;
        to_count = 0;
        rst      = 1'b0;
        tog_cyc  = cyc;
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d expected pulses never arrived, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_cmp++;
        if ({bus.period_valid, bus.half_period, bus.match, bus.locked, bus.timeout} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got pv=%0b half=%0d match=%0b locked=%0b timeout=%0b, required all 0",
                     bus.period_valid, bus.half_period, bus.match, bus.locked, bus.timeout);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (pv_count != 0 || to_count != 0) begin
            n_err++;
            $display("FAIL reset_quiet: got pulses=%0d timeouts=%0d, required 0/0", pv_count, to_count);
        end
    endtask

    task automatic test_latency();
        logic [3:0] lat;
        do_reset(1'b0);
        tone_half(20);
        repeat (T) @(posedge clk);
        #8;
        bus.tone_in = ~bus.tone_in;
        model_edge(T);
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk);
            #1;
            lat[i] = bus.period_valid;
        end
        n_cmp++;
        if (lat !== 4'b0010) begin
            n_err++;
            $display("FAIL latency: got pv after k..k+3=%b, required 0010", lat);
        end
        drain("latency");
    endtask

    task automatic test_ideal();
        do_reset(1'b0);
        tone_half(100);
        for (int i = 0; i < 9; i++) tone_half(T);
        drain("ideal");
        n_cmp++;
        if (bus.locked !== 1'b1 || pv_count != 9) begin
            n_err++;
            $display("FAIL ideal_lock: got locked=%0b pulses=%0d, required 1/9", bus.locked, pv_count);
        end
    endtask

    task automatic test_tolerance();
        int seq[12];
        seq = '{T - TL, T + TL, T, T - TL - 1, T, T, T, T + TL + 1, T + TL, T - TL, T, T};
        do_reset(1'b0);
        tone_half(50);
        foreach (seq[i]) tone_half(seq[i]);
        drain("tolerance");
        n_cmp++;
        if (bus.locked !== 1'b1 || bus.half_period !== 15'(T)) begin
            n_err++;
            $display("FAIL tolerance_end: got locked=%0b half=%0d, required 1/%0d", bus.locked, bus.half_period, T);
        end
    endtask

    task automatic test_lock_loss();
        do_reset(1'b0);
        tone_half(50);
        for (int i = 0; i < 4; i++) tone_half(T);
        drain("lock_pre");
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL lock_pre: got locked=%0b, required 1", bus.locked);
        end
        tone_half(5000);
        drain("lock_break");
        n_cmp++;
        if ({bus.half_period, bus.match, bus.locked} !== {15'd5000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL lock_break: got half=%0d match=%0b locked=%0b, required 5000/0/0",
                     bus.half_period, bus.match, bus.locked);
        end
        for (int i = 0; i < 4; i++) tone_half(T);
        drain("relock");
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL relock: got locked=%0b, required 1", bus.locked);
        end
    endtask

    task automatic test_reset_high();
        do_reset(1'b1);
        tone_half(T);
        n_cmp++;
        if (pv_count != 0) begin
            n_err++;
            $display("FAIL spurious_edge: got %0d pulses before first toggle, required 0", pv_count);
        end
        tone_half(T);
        drain("reset_high");
        n_cmp++;
        if (pv_count != 2) begin
            n_err++;
            $display("FAIL reset_high_count: got %0d pulses, required 2", pv_count);
        end
    endtask

    task automatic test_reset_locked();
        do_reset(1'b0);
        tone_half(50);
        for (int i = 0; i < 4; i++) tone_half(T);
        drain("reset_locked");
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL reset_locked_pre: got locked=%0b, required 1", bus.locked);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.period_valid, bus.half_period, bus.match, bus.locked, bus.timeout} !== 19'd0) begin
            n_err++;
            $display("FAIL async_reset: got pv=%0b half=%0d match=%0b locked=%0b timeout=%0b, required all 0",
                     bus.period_valid, bus.half_period, bus.match, bus.locked, bus.timeout);
        end
        do_reset(1'b0);
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        tone_half(50);
        for (int i = 0; i < 4; i++) tone_half(T);
        drain("timeout_pre");
        for (int i = 0; i < 33000 && to_count == 0; i++) @(negedge clk);
        n_cmp++;
        if (to_count != 1) begin
            n_err++;
            $display("FAIL timeout_seen: got %0d timeout pulses, required 1", to_count);
        end
        n_cmp++;
        if (to_cyc - last_pv_cyc != 32767) begin
            n_err++;
            $display("FAIL timeout_delay: got %0d cycles after last pulse, required 32767", to_cyc - last_pv_cyc);
        end
        n_cmp++;
        if ({to_locked, to_match, to_half} !== {1'b0, 1'b0, 15'(T)}) begin
            n_err++;
            $display("FAIL timeout_outputs: got locked=%0b match=%0b half=%0d, required 0/0/%0d",
                     to_locked, to_match, to_half, T);
        end
        repeat (2000) @(negedge clk);
        n_cmp++;
        if (to_count != 1) begin
            n_err++;
            $display("FAIL timeout_single: got %0d timeout pulses, required 1", to_count);
        end
        m_armed  = 1'b0;
        m_cnt    = 0;
        m_locked = 1'b0;
        tone_half(50);
        tone_half(T);
        drain("timeout_post");
        n_cmp++;
        if (pv_count != 5 || bus.locked !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_rearm: got pulses=%0d locked=%0b, required 5/0", pv_count, bus.locked);
        end
    endtask

    initial begin
        bus.tone_in = 1'b0;
        test_reset();
        test_latency();
        test_ideal();
        test_tolerance();
        test_lock_loss();
        test_reset_high();
        test_reset_locked();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
